// File: rtl/wb_slave_pkg.sv
// Shared types, select constants and the select-validity check for the
// pipelined Wishbone register slave.
package wb_slave_pkg;

    // One outstanding response: write or read, and whether it ends in ERR.
    typedef struct packed {
        logic we;
        logic err;
    } resp_entry_t;

    localparam logic [3:0] SEL_WORD    = 4'b1111;
    localparam logic [3:0] SEL_HALF_LO = 4'b0011;
    localparam logic [3:0] SEL_HALF_HI = 4'b1100;

    // Word needs a word-aligned address, halfwords need an even address;
    // single-byte lanes are legal only when byte access is enabled.
    function automatic logic sel_valid(input logic [3:0] sel,
                                       input logic [1:0] adr_lo,
                                       input logic       byte_en);
        logic ok;
        ok = 1'b0;
        if (sel == SEL_WORD && adr_lo == 2'b00) begin
            ok = 1'b1;
        end
        if ((sel == SEL_HALF_LO || sel == SEL_HALF_HI) && !adr_lo[0]) begin
            ok = 1'b1;
        end
        if (byte_en && sel == (4'b0001 << adr_lo)) begin
            ok = 1'b1;
        end
        return ok;
    endfunction

endpackage

// File: rtl/wb_resp_fifo.sv
// In-order queue of pending Wishbone responses with a synchronous clear.
module wb_resp_fifo
    import wb_slave_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     push,
    input  logic                     pop,
    input  resp_entry_t              din,
    output resp_entry_t              head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    resp_entry_t   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign head    = mem[rd_ptr];

    // Storage needs no reset; only pointer/count state defines validity.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/wb_pipe_slave_ctrl.sv
// Pipelined Wishbone register-slave controller: decodes requests, strobes
// the core, and returns in-order ACK/ERR with registered read data.
// Optional read-response timeout: define WB_SLAVE_TIMEOUT_EN.
module wb_pipe_slave_ctrl
    import wb_slave_pkg::*;
#(
    parameter int WB_ADDR_MSB = 11,
    parameter int WB_ADDR_LSB = 8,
    parameter int WB_ADDR_VAL = 0,
    parameter int DEPTH       = 4,
    parameter int BYTE_EN     = 1,
    parameter int ERR_ON_MISS = 0,
    parameter int TIMEOUT     = 64
) (
    input  logic        CLK,
    input  logic        RST_ASYNC_N,
    input  logic        RST_SYNC,
    input  logic [31:0] WB_REGS_ADR_IN,
    input  logic        WB_REGS_CYC_IN,
    input  logic        WB_REGS_STB_IN,
    input  logic        WB_REGS_WE_IN,
    input  logic [3:0]  WB_REGS_SEL_IN,
    output logic        WB_REGS_ACK_OUT,
    output logic        WB_REGS_ERR_OUT,
    output logic        WB_REGS_STALL_OUT,
    output logic [31:0] WB_REGS_DAT_RD_OUT,
    output logic        WB_WRITE_ADDR_STB_OUT,
    output logic        WB_READ_ADDR_STB_OUT,
    output logic        WB_VALID_OUT,
    input  logic [31:0] CORE_RD_DAT_IN,
    input  logic        CORE_RD_VLD_IN
);

    localparam int FW = WB_ADDR_MSB - WB_ADDR_LSB + 1;
    localparam logic [FW-1:0] FIELD_VAL = FW'(WB_ADDR_VAL);
    localparam logic MISS_ERR = (ERR_ON_MISS != 0);
    localparam logic BYTE_OK  = (BYTE_EN != 0);

    logic                   hit;
    logic                   accept;
    logic                   take;
    logic                   flush;
    logic                   resp_valid;
    logic                   retire;
    logic                   ack_d;
    logic                   err_d;
    logic                   load_dat;
    logic                   expire;
    logic                   fifo_push;
    logic                   fifo_pop;
    logic                   full;
    logic                   empty;
    logic [$clog2(DEPTH):0] count;
    resp_entry_t            in_entry;
    resp_entry_t            head;
    resp_entry_t            cur;
    logic                   ack_q;
    logic                   err_q;
    logic [31:0]            dat_q;

    assign hit = (WB_REGS_ADR_IN[WB_ADDR_MSB:WB_ADDR_LSB] == FIELD_VAL)
               & sel_valid(WB_REGS_SEL_IN, WB_REGS_ADR_IN[1:0], BYTE_OK);

    assign accept   = WB_REGS_CYC_IN & WB_REGS_STB_IN & ~full;
    assign take     = accept & (hit | MISS_ERR);
    assign flush    = ~WB_REGS_CYC_IN & (count != '0);
    assign in_entry = '{we: WB_REGS_WE_IN, err: ~hit};

    // With an empty queue the incoming request is itself the head, so a
    // write, an error or a read with data already present retires in its
    // accept cycle and never occupies a FIFO slot.
    assign cur        = empty ? in_entry : head;
    assign resp_valid = take | (~empty & ~flush);
    assign fifo_push  = take & ~(empty & retire);
    assign fifo_pop   = retire & ~empty;

    // Decide whether the current head retires this cycle and how.
    always_comb begin
        retire   = 1'b0;
        ack_d    = 1'b0;
        err_d    = 1'b0;
        load_dat = 1'b0;
        if (resp_valid) begin
            if (cur.err) begin
                retire = 1'b1;
                err_d  = 1'b1;
            end else if (cur.we) begin
                retire = 1'b1;
                ack_d  = 1'b1;
            end else if (CORE_RD_VLD_IN) begin
                retire   = 1'b1;
                ack_d    = 1'b1;
                load_dat = 1'b1;
            end else if (expire) begin
                retire = 1'b1;
                err_d  = 1'b1;
            end
        end
    end

`ifdef WB_SLAVE_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic          head_read_wait;
    logic [TW-1:0] tmo_cnt;

    assign head_read_wait = ~empty & ~flush & ~head.we & ~head.err;
    assign expire = head_read_wait & (tmo_cnt == TW'(TIMEOUT - 1));

    // Count cycles a queued read waits at the head; restart on any pop.
    always_ff @(posedge CLK or negedge RST_ASYNC_N) begin
        if (!RST_ASYNC_N) begin
            tmo_cnt <= '0;
        end else if (RST_SYNC || !head_read_wait || fifo_pop) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end
`else
    assign expire = 1'b0;
`endif

    wb_resp_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (CLK),
        .rst_n (RST_ASYNC_N),
        .clr   (RST_SYNC | flush),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (in_entry),
        .head  (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    // Registered responses; read data holds except on read ACK or on ERR.
    always_ff @(posedge CLK or negedge RST_ASYNC_N) begin
        if (!RST_ASYNC_N) begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            dat_q <= '0;
        end else if (RST_SYNC) begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            dat_q <= '0;
        end else begin
            ack_q <= ack_d;
            err_q <= err_d;
            if (load_dat) begin
                dat_q <= CORE_RD_DAT_IN;
            end else if (err_d) begin
                dat_q <= '0;
            end
        end
    end

    assign WB_REGS_ACK_OUT       = ack_q;
    assign WB_REGS_ERR_OUT       = err_q;
    assign WB_REGS_DAT_RD_OUT    = dat_q;
    assign WB_REGS_STALL_OUT     = full;
    assign WB_WRITE_ADDR_STB_OUT = accept & hit & WB_REGS_WE_IN;
    assign WB_READ_ADDR_STB_OUT  = accept & hit & ~WB_REGS_WE_IN;
    assign WB_VALID_OUT          = hit;

endmodule

// File: tb/tb_wb_pipe_slave_ctrl.sv
// Self-checking bench for wb_pipe_slave_ctrl with a queue-based reference
// model of the request/response protocol.
module tb_wb_pipe_slave_ctrl;

    localparam int DEPTH       = 4;
    localparam int BYTE_EN     = 1;
    localparam int ERR_ON_MISS = 1;
    localparam int TIMEOUT     = 8;

    typedef struct {
        bit we;
        bit err;
    } req_t;

    logic        clk = 1'b0;
    logic        rst_async_n;
    logic        rst_sync;
    logic [31:0] adr;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  sel;
    logic        ack;
    logic        err;
    logic        stall;
    logic [31:0] dat_rd;
    logic        wr_stb;
    logic        rd_stb;
    logic        valid;
    logic [31:0] core_dat;
    logic        core_vld;

    int total = 0;
    int bad   = 0;

    req_t        mq[$];
    logic        m_ack;
    logic        m_err;
    logic [31:0] m_dat;
    int          m_wait;

    logic [3:0]  exp_comb;
    logic [3:0]  obs_comb;
    logic [33:0] exp_reg;
    logic [33:0] obs_reg;

    always #5 clk = ~clk;

    wb_pipe_slave_ctrl #(
        .WB_ADDR_MSB (11),
        .WB_ADDR_LSB (8),
        .WB_ADDR_VAL (0),
        .DEPTH       (DEPTH),
        .BYTE_EN     (BYTE_EN),
        .ERR_ON_MISS (ERR_ON_MISS),
        .TIMEOUT     (TIMEOUT)
    ) dut (
        .CLK                   (clk),
        .RST_ASYNC_N           (rst_async_n),
        .RST_SYNC              (rst_sync),
        .WB_REGS_ADR_IN        (adr),
        .WB_REGS_CYC_IN        (cyc),
        .WB_REGS_STB_IN        (stb),
        .WB_REGS_WE_IN         (we),
        .WB_REGS_SEL_IN        (sel),
        .WB_REGS_ACK_OUT       (ack),
        .WB_REGS_ERR_OUT       (err),
        .WB_REGS_STALL_OUT     (stall),
        .WB_REGS_DAT_RD_OUT    (dat_rd),
        .WB_WRITE_ADDR_STB_OUT (wr_stb),
        .WB_READ_ADDR_STB_OUT  (rd_stb),
        .WB_VALID_OUT          (valid),
        .CORE_RD_DAT_IN        (core_dat),
        .CORE_RD_VLD_IN        (core_vld)
    );

    // Address field [11:8] must be zero; select legality from the lane rules.
    function automatic bit spec_hit(input logic [31:0] a, input logic [3:0] s);
        int lo;
        bit sel_ok;
        lo     = int'(a % 4);
        sel_ok = 1'b0;
        if (s == 4'hF && lo == 0) sel_ok = 1'b1;
        if ((s == 4'h3 || s == 4'hC) && (lo % 2) == 0) sel_ok = 1'b1;
        if (BYTE_EN == 1 && int'(s) == (1 << lo)) sel_ok = 1'b1;
        return sel_ok && (((a / 256) % 16) == 0);
    endfunction

    task automatic model_clear();
        mq.delete();
        m_ack  = 1'b0;
        m_err  = 1'b0;
        m_dat  = '0;
        m_wait = 0;
    endtask

    task automatic set_idle();
        cyc      = 1'b0;
        stb      = 1'b0;
        we       = 1'b0;
        sel      = 4'h0;
        adr      = '0;
        core_vld = 1'b0;
        core_dat = '0;
    endtask

    // One clock: snapshot combinational outputs before the edge, advance the
    // model at the edge, snapshot registered outputs after it.
    task automatic step();
        bit   acc;
        bit   h;
        int   pre;
        req_t e;
        #2;
        h        = spec_hit(adr, sel);
        acc      = cyc && stb && (mq.size() < DEPTH);
        exp_comb = {acc && h && we, acc && h && !we, mq.size() == DEPTH, h};
        obs_comb = {wr_stb, rd_stb, stall, valid};
        @(posedge clk);
        pre   = mq.size();
        m_ack = 1'b0;
        m_err = 1'b0;
        if (rst_sync) begin
            model_clear();
        end else if (!cyc && pre > 0) begin
            mq.delete();
            m_wait = 0;
        end else begin
            if (acc && (h || ERR_ON_MISS == 1)) begin
                e.we  = we;
                e.err = !h;
                mq.push_back(e);
            end
            if (mq.size() > 0) begin
                if (mq[0].err) begin
                    m_err = 1'b1;
                end else if (mq[0].we) begin
                    m_ack = 1'b1;
                end else if (core_vld) begin
                    m_ack = 1'b1;
                    m_dat = core_dat;
                end
`ifdef WB_SLAVE_TIMEOUT_EN
                else if (pre > 0) begin
                    m_wait++;
                    if (m_wait >= TIMEOUT) m_err = 1'b1;
                end
`endif
                if (m_ack || m_err) begin
                    mq.delete(0);
                    m_wait = 0;
                end
                if (m_err) m_dat = '0;
            end
        end
        exp_reg = {m_ack, m_err, m_dat};
        #1;
        obs_reg = {ack, err, dat_rd};
        @(negedge clk);
    endtask

    // Power-on reset, then an asynchronous reset with three reads queued.
    task automatic test_reset();
        set_idle();
        rst_sync    = 1'b0;
        rst_async_n = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if ({ack, err, stall, wr_stb, rd_stb} !== 5'b0 || dat_rd !== 32'h0) begin
            bad++;
            $display("[TB] FAIL reset_por: ack/err/stall/wstb/rstb=%b dat=%h, need 0", {ack, err, stall, wr_stb, rd_stb}, dat_rd);
        end
        rst_async_n = 1'b1;
        model_clear();
        cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; adr = 32'h0000_0004;
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (obs_comb !== exp_comb || obs_reg !== exp_reg) begin
                bad++;
                $display("[TB] FAIL reset_fill[%0d]: got %b %h, need %b %h", i, obs_comb, obs_reg, exp_comb, exp_reg);
            end
        end
        stb = 1'b0;
        #2;
        rst_async_n = 1'b0;
        #1;
        total++;
        if ({ack, err, stall, wr_stb, rd_stb} !== 5'b0 || dat_rd !== 32'h0) begin
            bad++;
            $display("[TB] FAIL reset_async: ack/err/stall/wstb/rstb=%b dat=%h, need 0", {ack, err, stall, wr_stb, rd_stb}, dat_rd);
        end
        model_clear();
        @(negedge clk);
        rst_async_n = 1'b1;
        core_vld = 1'b1;
        for (int i = 0; i < 3; i++) begin
            core_dat = $urandom;
            step();
            total++;
            if (obs_comb !== exp_comb || obs_reg !== exp_reg || obs_reg[33:32] !== 2'b00) begin
                bad++;
                $display("[TB] FAIL reset_after[%0d]: got %b %h, need %b %h", i, obs_comb, obs_reg, exp_comb, exp_reg);
            end
        end
        set_idle();
    endtask

    // Single write with its ACK next cycle, then four back-to-back writes.
    task automatic test_write();
        int acks;
        int stalls;
        cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hF; adr = 32'h0000_0000;
        step();
        total++;
        if (obs_comb !== exp_comb || obs_reg !== exp_reg || obs_comb[3] !== 1'b1 || obs_reg[33] !== 1'b1) begin
            bad++;
            $display("[TB] FAIL write_single: got %b %h, need %b %h", obs_comb, obs_reg, exp_comb, exp_reg);
        end
        acks   = 0;
        stalls = 0;
        for (int i = 0; i < 4; i++) begin
            adr = 32'h0000_0010 + 32'(4 * i);
            step();
            acks   += int'(obs_reg[33]);
            stalls += int'(obs_comb[1]);
            total++;
            if (obs_comb !== exp_comb || obs_reg !== exp_reg) begin
                bad++;
                $display("[TB] FAIL write_b2b[%0d]: got %b %h, need %b %h", i, obs_comb, obs_reg, exp_comb, exp_reg);
            end
        end
        total++;
        if (acks !== 4 || stalls !== 0) begin
            bad++;
            $display("[TB] FAIL write_b2b_count: acks=%0d stalls=%0d, need 4 and 0", acks, stalls);
        end
        stb = 1'b0;
        step();
    endtask

    // Fill the queue with reads, see STALL, then drain with core data.
    task automatic test_read_stall();
        cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; adr = 32'h0000_0008;
        for (int i = 0; i < 5; i++) begin
            step();
            total++;
            if (obs_comb !== exp_comb || obs_reg !== exp_reg || (i == 4 && obs_comb[2:1] !== 2'b01)) begin
                bad++;
                $display("[TB] FAIL read_fill[%0d]: got %b %h, need %b %h", i, obs_comb, obs_reg, exp_comb, exp_reg);
            end
        end
        stb = 1'b0;
        core_vld = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            core_dat = 32'hA5A5_0000 + 32'(k);
            step();
            total++;
            if (obs_comb !== exp_comb || obs_reg !== exp_reg || obs_reg !== {2'b10, 32'hA5A5_0000 + 32'(k)}) begin
                bad++;
                $display("[TB] FAIL read_drain[%0d]: got %b %h, need %b %h", k, obs_comb, obs_reg, exp_comb, exp_reg);
            end
        end
        core_vld = 1'b0;
        step();
        total++;
        if (obs_comb !== exp_comb || obs_reg !== exp_reg) begin
            bad++;
            $display("[TB] FAIL read_idle: got %b %h, need %b %h", obs_comb, obs_reg, exp_comb, exp_reg);
        end
    endtask

    // Decode misses and illegal selects end in ERR; a legal byte lane ACKs.
    task automatic test_miss();
        logic [31:0] adrs [3];
        logic [3:0]  sels [3];
        logic [1:0]  need [3];
        adrs[0] = 32'h0000_0100; sels[0] = 4'hF;    need[0] = 2'b01;
        adrs[1] = 32'h0000_0000; sels[1] = 4'b0110; need[1] = 2'b01;
        adrs[2] = 32'h0000_0002; sels[2] = 4'b0100; need[2] = 2'b10;
        cyc = 1'b1; stb = 1'b1; we = 1'b1;
        for (int i = 0; i < 3; i++) begin
            adr = adrs[i];
            sel = sels[i];
            step();
            total++;
            if (obs_comb !== exp_comb || obs_reg !== exp_reg || obs_reg[33:32] !== need[i]) begin
                bad++;
                $display("[TB] FAIL miss[%0d]: got %b %h, need %b %h", i, obs_comb, obs_reg, exp_comb, exp_reg);
            end
        end
        stb = 1'b0;
        step();
    endtask

    // A queued read is flushed by dropping CYC; late core data is discarded.
    task automatic test_abort();
        cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; adr = 32'h0000_0020;
        step();
        stb = 1'b0;
        step();
        cyc = 1'b0;
        step();
        cyc = 1'b1;
        core_vld = 1'b1;
        for (int i = 0; i < 2; i++) begin
            core_dat = $urandom;
            step();
            total++;
            if (obs_comb !== exp_comb || obs_reg !== exp_reg || obs_reg[33:32] !== 2'b00 || obs_comb[1] !== 1'b0) begin
                bad++;
                $display("[TB] FAIL abort[%0d]: got %b %h, need %b %h", i, obs_comb, obs_reg, exp_comb, exp_reg);
            end
        end
        core_vld = 1'b0;
    endtask

    // Read answered in its accept cycle, then RST_SYNC clears data and queue.
    task automatic test_sync_reset();
        cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; adr = 32'h0000_0030;
        core_vld = 1'b1; core_dat = 32'h1234_5678;
        step();
        total++;
        if (obs_reg !== exp_reg || obs_reg !== {2'b10, 32'h1234_5678}) begin
            bad++;
            $display("[TB] FAIL read_same_cycle: got %h, need %h", obs_reg, exp_reg);
        end
        core_vld = 1'b0;
        step();
        stb = 1'b0;
        rst_sync = 1'b1;
        step();
        rst_sync = 1'b0;
        total++;
        if (obs_reg !== exp_reg || obs_reg !== 34'h0) begin
            bad++;
            $display("[TB] FAIL sync_reset: got %h, need %h", obs_reg, exp_reg);
        end
        core_vld = 1'b1; core_dat = 32'hDEAD_BEEF;
        step();
        core_vld = 1'b0;
        total++;
        if (obs_comb !== exp_comb || obs_reg !== exp_reg) begin
            bad++;
            $display("[TB] FAIL sync_reset_after: got %b %h, need %b %h", obs_comb, obs_reg, exp_comb, exp_reg);
        end
    endtask

`ifdef WB_SLAVE_TIMEOUT_EN
    // Silent core times out after TIMEOUT head cycles; data in that cycle wins.
    task automatic test_timeout();
        for (int r = 0; r < 2; r++) begin
            cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; adr = 32'h0000_0040;
            step();
            stb = 1'b0;
            for (int i = 0; i < TIMEOUT; i++) begin
                core_vld = (r == 1 && i == TIMEOUT - 1);
                core_dat = 32'hC0DE_0001;
                step();
                total++;
                if (obs_comb !== exp_comb || obs_reg !== exp_reg ||
                    (i == TIMEOUT - 1 && obs_reg[33:32] !== ((r == 0) ? 2'b01 : 2'b10)) ||
                    (i < TIMEOUT - 1 && obs_reg[33:32] !== 2'b00)) begin
                    bad++;
                    $display("[TB] FAIL timeout[%0d][%0d]: got %b %h, need %b %h", r, i, obs_comb, obs_reg, exp_comb, exp_reg);
                end
            end
            core_vld = 1'b0;
        end
    endtask
`endif

    // Mixed random traffic, aborts and core responses against the model.
    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            cyc      = ($urandom_range(0, 15) != 0);
            stb      = ($urandom_range(0, 3) != 0);
            we       = ($urandom_range(0, 1) == 1);
            adr      = $urandom;
            adr[11:8] = ($urandom_range(0, 3) == 0) ? 4'h1 : 4'h0;
            case ($urandom_range(0, 4))
                0:       sel = 4'hF;
                1:       sel = 4'h3;
                2:       sel = 4'hC;
                3:       sel = 4'b0001 << adr[1:0];
                default: sel = 4'($urandom_range(0, 15));
            endcase
            core_vld = ($urandom_range(0, 2) == 0);
            core_dat = $urandom;
            step();
            total++;
            if (obs_comb !== exp_comb || obs_reg !== exp_reg) begin
                bad++;
                $display("[TB] FAIL random[%0d]: got %b %h, need %b %h", i, obs_comb, obs_reg, exp_comb, exp_reg);
            end
        end
        set_idle();
    endtask

    initial begin
        model_clear();
        test_reset();
        test_write();
        test_read_stall();
        test_miss();
        test_abort();
        test_sync_reset();
`ifdef WB_SLAVE_TIMEOUT_EN
        test_timeout();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
